// File: rtl/counter_pkg.sv
// Shared types and defaults for the programmable up/down counter.
package counter_pkg;

  // Counting modes; the unused encoding 3 falls back to WRAP behaviour.
  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2
  } mode_e;

  // One-shot sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } os_state_e;

  localparam int WIDTH_DEF  = 8;
  localparam int STEP_W_DEF = 4;

endpackage

// File: rtl/prog_counter_next.sv
// Combinational next-count generator shared by the free-running and
// one-shot paths. Produces the stepped value and a boundary flag; on a
// boundary the value is either the wrap target (WRAP / reserved mode) or the
// clamp target (SAT / ONESHOT).
module prog_counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  modulus,
  input  logic              up_dn,
  input  mode_e             mode,
  output logic [WIDTH-1:0]  next_count,
  output logic              boundary
);

  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           over_mod;
  logic           up_bnd;
  logic           dn_bnd;
  logic           clamp;

  assign step_x   = (WIDTH+1)'(step);
  assign sum      = {1'b0, count} + step_x;
  assign diff     = {1'b0, count} - step_x;
  // A count left above a lowered modulus is always a boundary when stepping.
  assign over_mod = count > modulus;
  assign up_bnd   = sum > {1'b0, modulus};
  // Borrow out of the subtraction means step > count.
  assign dn_bnd   = diff[WIDTH];
  assign clamp    = (mode == SAT) || (mode == ONESHOT);

  // Boundary detection and selection of stepped / wrapped / clamped value.
  always_comb begin
    boundary   = 1'b0;
    next_count = count;
    if (step != '0) begin
      boundary = over_mod || (up_dn ? up_bnd : dn_bnd);
      if (!boundary) begin
        next_count = up_dn ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
      end else if (clamp) begin
        next_count = up_dn ? modulus : {WIDTH{1'b0}};
      end else begin
        next_count = up_dn ? {WIDTH{1'b0}} : modulus;
      end
    end
  end

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with wrap, saturate and one-shot modes and a
// registered terminal-count pulse.
// Optional build macro PROG_COUNTER_STICKY_EN adds ovf_clr / ovf_sticky, a
// sticky record of any terminal-count pulse.
module prog_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [WIDTH-1:0]  data,
  input  logic              up_dn,
  input  mode_e             mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  modulus,
  input  logic              start,
`ifdef PROG_COUNTER_STICKY_EN
  input  logic              ovf_clr,
  output logic              ovf_sticky,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              busy,
  output logic              at_zero,
  output logic              at_max
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  os_state_e        state_q, state_d;

  logic [WIDTH-1:0] step_val;
  logic             step_bnd;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] run_bound;
  logic [WIDTH-1:0] run_init;
  logic             is_os;

  prog_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .count      (count_q),
    .step       (step),
    .modulus    (modulus),
    .up_dn      (up_dn),
    .mode       (mode),
    .next_count (step_val),
    .boundary   (step_bnd)
  );

  assign is_os     = (mode == ONESHOT);
  assign load_val  = (data > modulus) ? modulus : data;
  // A one-shot run starts at the far end and finishes at the near bound.
  assign run_bound = up_dn ? modulus : {WIDTH{1'b0}};
  assign run_init  = up_dn ? {WIDTH{1'b0}} : modulus;

  // Next-state logic: load > start (one-shot) > enable.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    state_d = state_q;
    if (!is_os) begin
      state_d = ST_IDLE;
    end
    if (load) begin
      count_d = load_val;
      state_d = ST_IDLE;
    end else if (is_os && start) begin
      count_d = run_init;
      state_d = ST_RUN;
    end else if (is_os) begin
      if ((state_q == ST_RUN) && enable && (step != '0)) begin
        count_d = step_val;
        if (step_val == run_bound) begin
          tc_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
    end else if (enable) begin
      count_d = step_val;
      if (mode == SAT) begin
        // Saturation only pulses when the count actually moves onto the bound.
        tc_d = step_bnd && (step_val != count_q);
      end else begin
        tc_d = step_bnd;
      end
    end
  end

  // Count, terminal-count and one-shot state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

`ifdef PROG_COUNTER_STICKY_EN
  logic sticky_q, sticky_d;

  // Sticky overflow: set with the tc pulse, set beats clear.
  always_comb begin
    sticky_d = tc_d | (sticky_q & ~ovf_clr);
  end

  // Sticky overflow register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`endif

  assign count   = count_q;
  assign tc      = tc_q;
  assign busy    = (state_q == ST_RUN);
  assign at_zero = (count_q == '0);
  assign at_max  = (count_q == modulus);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Self-checking bench for prog_updown_counter: directed vector table,
// hand-written async-reset sequences and a randomized run against a
// behavioural model.
module tb_prog_updown_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, load, up_dn, start;
  logic [7:0] data, modulus;
  logic [3:0] step;
  mode_e      mode;
  logic [7:0] count;
  logic       tc, busy, at_zero, at_max;
`ifdef PROG_COUNTER_STICKY_EN
  logic       ovf_clr, ovf_sticky;
`endif

  int total = 0;
  int bad   = 0;

  prog_updown_counter #(.WIDTH(8), .STEP_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .load    (load),
    .data    (data),
    .up_dn   (up_dn),
    .mode    (mode),
    .step    (step),
    .modulus (modulus),
    .start   (start),
`ifdef PROG_COUNTER_STICKY_EN
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky),
`endif
    .count   (count),
    .tc      (tc),
    .busy    (busy),
    .at_zero (at_zero),
    .at_max  (at_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ld, en, st, ud;
    int md, stp, md_mod, dat;
    int ec, et, eb;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit ld, en, st, ud, input int md, stp, mdl, dat, ec, et, eb);
    vec_t v;
    v.ld = ld; v.en = en; v.st = st; v.ud = ud;
    v.md = md; v.stp = stp; v.md_mod = mdl; v.dat = dat;
    v.ec = ec; v.et = et; v.eb = eb;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit ld, en, st, ud, input int md, stp, mdl, dat);
    load = ld; enable = en; start = st; up_dn = ud;
    mode = mode_e'(md[1:0]); step = stp[3:0]; modulus = mdl[7:0]; data = dat[7:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference model state.
  int m_cnt, m_tc, m_st, m_stk;

  task automatic model_reset();
    m_cnt = 0; m_tc = 0; m_st = 0; m_stk = 0;
  endtask

  // m_st: 0 idle, 1 running, 2 done.
  task automatic model_step(input bit ld, en, strt, ud, input int md, stp, mdl, dat, input bit clr);
    int raw, bound;
    bit oor, os;
    os    = (md == 2);
    bound = ud ? mdl : 0;
    raw   = ud ? m_cnt + stp : m_cnt - stp;
    oor   = (stp != 0) && (raw < 0 || raw > mdl || m_cnt > mdl);
    m_tc  = 0;
    if (ld) begin
      m_cnt = (dat < mdl) ? dat : mdl;
      m_st  = 0;
    end else if (os && strt) begin
      m_cnt = ud ? 0 : mdl;
      m_st  = 1;
    end else if (os) begin
      if (m_st == 1 && en && stp != 0) begin
        m_cnt = oor ? bound : raw;
        if (m_cnt == bound) begin
          m_tc = 1;
          m_st = 2;
        end
      end
    end else begin
      m_st = 0;
      if (en && stp != 0) begin
        if (!oor) m_cnt = raw;
        else if (md == 1) begin
          m_tc  = (m_cnt != bound) ? 1 : 0;
          m_cnt = bound;
        end else begin
          m_cnt = ud ? 0 : mdl;
          m_tc  = 1;
        end
      end
    end
    m_stk = (m_tc != 0 || (m_stk != 0 && !clr)) ? 1 : 0;
  endtask

  initial begin
    int k;
    bit r_ld, r_en, r_st, r_ud, r_clr;
    int r_md, r_stp, r_mod, r_dat;

    reset = 1'b1;
    drive(0, 0, 0, 1, 0, 0, 9, 0);
`ifdef PROG_COUNTER_STICKY_EN
    ovf_clr = 1'b0;
`endif
    #1;
    check("reset_count", count, 0);
    check("reset_tc", tc, 0);
    check("reset_busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;

    // ld en st ud md stp mod dat | count tc busy
    addv(1,0,0,1,0,3,9,0,     0,0,0);
    addv(0,1,0,1,0,3,9,0,     3,0,0);
    addv(0,1,0,1,0,3,9,0,     6,0,0);
    addv(0,1,0,1,0,3,9,0,     9,0,0);
    addv(0,1,0,1,0,3,9,0,     0,1,0);
    addv(1,0,0,0,0,4,9,2,     2,0,0);
    addv(0,1,0,0,0,4,9,0,     9,1,0);
    addv(0,1,0,0,0,4,9,0,     5,0,0);
    addv(0,1,0,0,0,4,9,0,     1,0,0);
    addv(0,1,0,0,0,4,9,0,     9,1,0);
    addv(1,1,0,1,0,1,64,80,   64,0,0);
    addv(1,0,0,1,1,15,200,190, 190,0,0);
    addv(0,1,0,1,1,15,200,0,  200,1,0);
    addv(0,1,0,1,1,15,200,0,  200,0,0);
    addv(1,0,0,0,1,7,200,5,   5,0,0);
    addv(0,1,0,0,1,7,200,0,   0,1,0);
    addv(0,1,0,0,1,7,200,0,   0,0,0);
    addv(0,1,0,1,0,2,0,0,     0,1,0);
    addv(0,1,0,1,0,2,0,0,     0,1,0);
    addv(1,0,0,1,0,1,9,7,     7,0,0);
    addv(0,0,0,1,0,1,3,0,     7,0,0);
    addv(0,1,0,1,0,1,3,0,     0,1,0);
    addv(1,0,0,1,0,0,9,4,     4,0,0);
    addv(0,1,0,1,0,0,9,0,     4,0,0);
    addv(0,1,0,1,3,6,9,0,     0,1,0);
    addv(0,0,1,1,2,1,5,0,     0,0,1);
    for (int i = 1; i <= 4; i++) addv(0,1,0,1,2,1,5,0, i,0,1);
    addv(0,1,0,1,2,1,5,0,     5,1,0);
    addv(0,1,0,1,2,1,5,0,     5,0,0);
    addv(0,0,1,1,2,1,5,0,     0,0,1);
    for (int i = 1; i <= 3; i++) addv(0,1,0,1,2,1,5,0, i,0,1);
    addv(0,1,1,1,2,1,5,0,     0,0,1);
    addv(0,1,0,1,2,1,5,0,     1,0,1);
    addv(0,0,0,1,0,1,5,0,     1,0,0);
    addv(0,0,1,0,2,3,5,0,     5,0,1);
    addv(0,1,0,0,2,3,5,0,     2,0,1);
    addv(0,1,0,0,2,3,5,0,     0,1,0);

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].en, tbl[i].st, tbl[i].ud, tbl[i].md, tbl[i].stp, tbl[i].md_mod, tbl[i].dat);
      tick();
      check($sformatf("vec%0d_count", i), count, tbl[i].ec);
      check($sformatf("vec%0d_tc", i), tc, tbl[i].et);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      check($sformatf("vec%0d_at_zero", i), at_zero, (tbl[i].ec == 0) ? 1 : 0);
      check($sformatf("vec%0d_at_max", i), at_max, (tbl[i].ec == tbl[i].md_mod) ? 1 : 0);
    end

    // Asynchronous reset mid-count: clears without waiting for an edge.
    drive(1, 0, 0, 1, 0, 1, 255, 8'h37);
    tick();
    check("preload_37", count, 8'h37);
    drive(0, 1, 0, 1, 0, 1, 255, 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_tc", tc, 0);
    tick();
    reset = 1'b0;
    tick();
    check("resume_after_rst", count, 1);

    // Reset during a one-shot run drops busy immediately.
    drive(0, 0, 1, 1, 2, 1, 5, 0);
    tick();
    drive(0, 1, 0, 1, 2, 1, 5, 0);
    tick();
    check("os_run_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("os_rst_busy", busy, 0);
    check("os_rst_count", count, 0);
    tick();
    reset = 1'b0;

`ifdef PROG_COUNTER_STICKY_EN
    drive(1, 0, 0, 1, 0, 1, 9, 9);
    tick();
    check("stk_initial", ovf_sticky, 0);
    drive(0, 1, 0, 1, 0, 1, 9, 0);
    tick();
    check("stk_set_tc", tc, 1);
    check("stk_set", ovf_sticky, 1);
    drive(0, 0, 0, 1, 0, 1, 9, 0);
    tick();
    tick();
    check("stk_hold", ovf_sticky, 1);
    ovf_clr = 1'b1;
    tick();
    check("stk_clr", ovf_sticky, 0);
    ovf_clr = 1'b0;
    drive(1, 0, 0, 1, 0, 1, 9, 9);
    tick();
    ovf_clr = 1'b1;
    drive(0, 1, 0, 1, 0, 1, 9, 0);
    tick();
    check("stk_set_wins", ovf_sticky, 1);
    ovf_clr = 1'b0;
`endif

    // Randomized run against the behavioural model.
    reset = 1'b1;
    #1;
    model_reset();
    tick();
    reset = 1'b0;
    r_mod = 9;
    r_md  = 0;
    for (k = 0; k < 3000; k++) begin
      r_ld  = ($urandom_range(0, 19) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_st  = ($urandom_range(0, 24) == 0);
      r_ud  = ($urandom_range(0, 5) != 0) ? r_ud : ~r_ud;
      r_stp = $urandom_range(0, 15);
      r_dat = $urandom_range(0, 255);
      r_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0)
        r_mod = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      if ($urandom_range(0, 29) == 0) r_md = $urandom_range(0, 3);
      drive(r_ld, r_en, r_st, r_ud, r_md, r_stp, r_mod, r_dat);
`ifdef PROG_COUNTER_STICKY_EN
      ovf_clr = r_clr;
`endif
      model_step(r_ld, r_en, r_st, r_ud, r_md, r_stp, r_mod, r_dat, r_clr);
      tick();
      check("rnd_count", count, m_cnt);
      check("rnd_tc", tc, m_tc);
      check("rnd_busy", busy, (m_st == 1) ? 1 : 0);
      check("rnd_at_zero", at_zero, (m_cnt == 0) ? 1 : 0);
      check("rnd_at_max", at_max, (m_cnt == r_mod) ? 1 : 0);
`ifdef PROG_COUNTER_STICKY_EN
      check("rnd_sticky", ovf_sticky, m_stk);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
